// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the program counter and picks the next fetch PC.
// Each cycle the next PC is one of: sequential +4, a branch/jump
// redirect, a stall hold, or a frozen PC while a halt drains.
// The block also drives the IF/ID and ID/EX squash strobes and a
// fetch-valid qualifier for the IF/ID register.
module pc_fetch_ctrl #(
  parameter int unsigned          PC_W      = 9,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter int unsigned          DRAIN_CYC = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            stall,
  input  logic            halt_req,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            halted,
  output logic            misalign_err,
  output logic [15:0]     redirect_cnt
);

  // The drain counter counts down from DRAIN_CYC-1 to 0.
  localparam int unsigned    CNT_W      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);
  localparam logic [PC_W-1:0]  PC_STEP    = PC_W'(4);
  localparam logic [15:0]      CNT_MAX    = 16'hFFFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] drain_cnt;

  logic             redir;
  logic             bad;
  logic             good;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  pc_seq;
  logic [15:0]      cnt_inc;

  // Target bits above the PC width carry no meaning for this core.
  logic             br_hi_unused;
  assign br_hi_unused = ^BrPC[31:PC_W];

  // Redirect qualification: HALT ignores the branch unit entirely.
  assign redir   = PcSel & (state != HALT);
  assign bad     = redir & (BrPC[1:0] != 2'b00);
  assign good    = redir & ~bad;
  assign target  = BrPC[PC_W-1:0];
  assign pc_seq  = pc + PC_STEP;
  assign cnt_inc = (redirect_cnt == CNT_MAX) ? redirect_cnt : redirect_cnt + 16'd1;

  // Squash strobes fire in the redirect cycle so the younger
  // instructions are dropped at the same edge the PC moves.
  assign flush_if_id = rst_n & good;
  assign flush_id_ex = rst_n & good;

  // A fetched word is only usable while running and not held by a hazard.
  assign fetch_valid = rst_n & (state == RUN) & ~stall;

  // PC, state, drain counter and sticky status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      pc           <= RESET_PC;
      drain_cnt    <= '0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (good) begin
            pc           <= target;
            redirect_cnt <= cnt_inc;
          end else if (bad) begin
            misalign_err <= 1'b1;
            halted       <= 1'b1;
            state        <= HALT;
          end else if (halt_req) begin
            drain_cnt    <= DRAIN_LOAD;
            state        <= DRAIN;
          end else if (!stall) begin
            pc           <= pc_seq;
          end
        end

        DRAIN: begin
          if (good) begin
            // An older branch resolved taken, so the halt was speculative.
            pc           <= target;
            redirect_cnt <= cnt_inc;
            drain_cnt    <= '0;
            state        <= RUN;
          end else if (bad) begin
            misalign_err <= 1'b1;
            halted       <= 1'b1;
            state        <= HALT;
          end else if (drain_cnt == '0) begin
            halted       <= 1'b1;
            state        <= HALT;
          end else begin
            drain_cnt    <= drain_cnt - CNT_W'(1);
          end
        end

        HALT: begin
          halted <= 1'b1;
        end

        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed table vectors plus hand-written sequences
// for drain cancellation, misaligned redirect, async reset and PC wrap.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        PcSel;
  logic [31:0] BrPC;
  logic        stall;
  logic        halt_req;
  logic [8:0]  pc;
  logic        fetch_valid;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        halted;
  logic        misalign_err;
  logic [15:0] redirect_cnt;

  int checks   = 0;
  int failures = 0;

  pc_fetch_ctrl #(
    .PC_W      (9),
    .RESET_PC  (9'h000),
    .DRAIN_CYC (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PcSel        (PcSel),
    .BrPC         (BrPC),
    .stall        (stall),
    .halt_req     (halt_req),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .halted       (halted),
    .misalign_err (misalign_err),
    .redirect_cnt (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] br;
    logic        st;
    logic        hr;
    logic [8:0]  e_pc;
    logic        e_fv;
    logic        e_fl;
    logic        e_hd;
    logic        e_mis;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vec [NVEC];

  task automatic apply(input logic s, input logic [31:0] b, input logic st, input logic hr);
    PcSel    = s;
    BrPC     = b;
    stall    = st;
    halt_req = hr;
    #1;
  endtask

  task automatic chk(input string nm, input logic [8:0] e_pc, input logic e_fv,
                     input logic e_fl, input logic e_hd, input logic e_mis,
                     input logic [15:0] e_cnt);
    checks++;
    if (pc !== e_pc) begin
      failures++;
      $display("FAIL %s pc got=%h exp=%h", nm, pc, e_pc);
    end
    checks++;
    if (fetch_valid !== e_fv) begin
      failures++;
      $display("FAIL %s fetch_valid got=%b exp=%b", nm, fetch_valid, e_fv);
    end
    checks++;
    if (flush_if_id !== e_fl) begin
      failures++;
      $display("FAIL %s flush_if_id got=%b exp=%b", nm, flush_if_id, e_fl);
    end
    checks++;
    if (flush_id_ex !== e_fl) begin
      failures++;
      $display("FAIL %s flush_id_ex got=%b exp=%b", nm, flush_id_ex, e_fl);
    end
    checks++;
    if (halted !== e_hd) begin
      failures++;
      $display("FAIL %s halted got=%b exp=%b", nm, halted, e_hd);
    end
    checks++;
    if (misalign_err !== e_mis) begin
      failures++;
      $display("FAIL %s misalign_err got=%b exp=%b", nm, misalign_err, e_mis);
    end
    checks++;
    if (redirect_cnt !== e_cnt) begin
      failures++;
      $display("FAIL %s redirect_cnt got=%h exp=%h", nm, redirect_cnt, e_cnt);
    end
  endtask

  initial begin
    //           sel br            st hr  pc      fv fl hd mis cnt
    vec[0]  = '{0, 32'h0,        0, 0, 9'h000, 1, 0, 0, 0, 16'd0};
    vec[1]  = '{0, 32'h0,        0, 0, 9'h004, 1, 0, 0, 0, 16'd0};
    vec[2]  = '{0, 32'h0,        0, 0, 9'h008, 1, 0, 0, 0, 16'd0};
    vec[3]  = '{0, 32'h0,        0, 0, 9'h00C, 1, 0, 0, 0, 16'd0};
    vec[4]  = '{0, 32'h0,        0, 0, 9'h010, 1, 0, 0, 0, 16'd0};
    vec[5]  = '{1, 32'h8,        0, 0, 9'h014, 1, 1, 0, 0, 16'd0};
    vec[6]  = '{1, 32'hFFFF_FE40,0, 0, 9'h008, 1, 1, 0, 0, 16'd1};
    vec[7]  = '{1, 32'h20,       1, 1, 9'h040, 0, 1, 0, 0, 16'd2};
    vec[8]  = '{0, 32'h0,        1, 0, 9'h020, 0, 0, 0, 0, 16'd3};
    vec[9]  = '{0, 32'h0,        0, 0, 9'h020, 1, 0, 0, 0, 16'd3};
    vec[10] = '{1, 32'h10,       0, 0, 9'h024, 1, 1, 0, 0, 16'd3};
    vec[11] = '{0, 32'h0,        0, 1, 9'h010, 1, 0, 0, 0, 16'd4};
    vec[12] = '{0, 32'h0,        1, 0, 9'h010, 0, 0, 0, 0, 16'd4};
    vec[13] = '{0, 32'h0,        0, 0, 9'h010, 0, 0, 0, 0, 16'd4};
    vec[14] = '{0, 32'h0,        0, 0, 9'h010, 0, 0, 0, 0, 16'd4};
    vec[15] = '{1, 32'h40,       0, 0, 9'h010, 0, 0, 1, 0, 16'd4};
    vec[16] = '{1, 32'h42,       1, 1, 9'h010, 0, 0, 1, 0, 16'd4};
    vec[17] = '{0, 32'h0,        0, 0, 9'h010, 0, 0, 1, 0, 16'd4};

    // Reset with a live redirect request on the inputs.
    rst_n    = 1'b0;
    PcSel    = 1'b1;
    BrPC     = 32'h40;
    stall    = 1'b0;
    halt_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset", 9'h000, 0, 0, 0, 0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: free run, redirects, redirect priority, halt drain, HALT.
    for (int i = 0; i < NVEC; i++) begin
      apply(vec[i].sel, vec[i].br, vec[i].st, vec[i].hr);
      chk($sformatf("vec%0d", i), vec[i].e_pc, vec[i].e_fv, vec[i].e_fl,
          vec[i].e_hd, vec[i].e_mis, vec[i].e_cnt);
      @(negedge clk);
    end

    // Async reset while halted.
    #3 rst_n = 1'b0;
    #1 chk("rst_halt", 9'h000, 0, 0, 0, 0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Redirect in the 2nd drain cycle cancels the halt.
    apply(0, 32'h0, 0, 1);  chk("t5_req",  9'h000, 1, 0, 0, 0, 16'd0); @(negedge clk);
    apply(0, 32'h0, 0, 0);  chk("t5_d1",   9'h000, 0, 0, 0, 0, 16'd0); @(negedge clk);
    apply(1, 32'h80, 1, 0); chk("t5_d2",   9'h000, 0, 1, 0, 0, 16'd0); @(negedge clk);
    apply(0, 32'h0, 0, 0);  chk("t5_run",  9'h080, 1, 0, 0, 0, 16'd1); @(negedge clk);
    apply(0, 32'h0, 0, 0);  chk("t5_seq",  9'h084, 1, 0, 0, 0, 16'd1); @(negedge clk);

    // Async reset in the middle of a drain.
    apply(0, 32'h0, 0, 1);  chk("md_req",  9'h088, 1, 0, 0, 0, 16'd1); @(negedge clk);
    apply(0, 32'h0, 0, 0);  chk("md_drain",9'h088, 0, 0, 0, 0, 16'd1);
    #2 rst_n = 1'b0;
    #1 chk("md_rst", 9'h000, 0, 0, 0, 0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Misaligned redirect: no flush, PC holds, sticky error and halt.
    apply(1, 32'h42, 0, 0); chk("t6_bad",  9'h000, 1, 0, 0, 0, 16'd0); @(negedge clk);
    apply(0, 32'h0, 0, 0);  chk("t6_halt", 9'h000, 0, 0, 1, 1, 16'd0); @(negedge clk);
    apply(0, 32'h0, 0, 0);  chk("t6_hold", 9'h000, 0, 0, 1, 1, 16'd0);
    #3 rst_n = 1'b0;
    #1 chk("t6_rst", 9'h000, 0, 0, 0, 0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // PC wraps modulo 2**9.
    apply(1, 32'h1FC, 0, 0); chk("wrap_br",   9'h000, 1, 1, 0, 0, 16'd0); @(negedge clk);
    apply(0, 32'h0, 0, 0);   chk("wrap_top",  9'h1FC, 1, 0, 0, 0, 16'd1); @(negedge clk);
    apply(0, 32'h0, 0, 0);   chk("wrap_zero", 9'h000, 1, 0, 0, 0, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
